// File: rtl/run_monitor.sv
// run_monitor
//   Launch and measurement stage between the stimulus driver and the design top.
//   A start request becomes a single-cycle enable pulse. The stage then counts
//   cycles until top raises valid, or declares a hang at TIMEOUT_CYC. Results
//   are accumulated over a batch of 2**LOG2_RUNS runs, and the average latency
//   is reported once the batch is complete.
//
// Ports
//   clk        in   1            clock, rising edge
//   srst       in   1            synchronous reset, active-high
//   start      in   1            run request, level sampled
//   enable     out  1            one-cycle launch pulse to top
//   valid      in   1            completion from top, sampled only while running
//   busy       out  1            a run is being launched or measured
//   done       out  1            one-cycle pulse on normal completion
//   latency    out  CNT_W        latency of the last completed run
//   run_num    out  LOG2_RUNS+1  completed runs in the current batch
//   avg_cyc    out  CNT_W        batch average latency, meaningful when avg_valid
//   avg_valid  out  1            batch complete, held until srst
//   timeout    out  1            sticky hang flag, cleared only by srst
module run_monitor #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int LOG2_RUNS   = 2,
    parameter int ACC_W       = 40
) (
    input  logic                 clk,
    input  logic                 srst,
    input  logic                 start,
    output logic                 enable,
    input  logic                 valid,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     latency,
    output logic [LOG2_RUNS:0]   run_num,
    output logic [CNT_W-1:0]     avg_cyc,
    output logic                 avg_valid,
    output logic                 timeout
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_HUNG   = 3'd4;

    localparam logic [LOG2_RUNS:0] RUNS_FULL   = {1'b1, {LOG2_RUNS{1'b0}}};
    localparam logic [CNT_W-1:0]   TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

    logic [2:0]         state_r;
    logic [2:0]         state_nxt_s;
    logic [CNT_W-1:0]   counter_r;
    logic [ACC_W-1:0]   total_r;
    logic               enable_r;
    logic               busy_r;
    logic               done_r;
    logic [CNT_W-1:0]   latency_r;
    logic [LOG2_RUNS:0] run_num_r;
    logic [CNT_W-1:0]   avg_cyc_r;
    logic               avg_valid_r;
    logic               timeout_r;
    logic               run_done_s;
    logic               at_limit_s;
    logic               batch_full_s;

    assign run_done_s   = (state_r == ST_RUN) && valid;
    assign at_limit_s   = (counter_r == TIMEOUT_VAL);
    assign batch_full_s = (run_num_r == RUNS_FULL);

    // Next-state decode. valid takes priority over the timeout threshold.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start && !batch_full_s) begin
                    state_nxt_s = ST_LAUNCH;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_LAUNCH: state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (valid) begin
                    state_nxt_s = ST_DONE;
                end else if (at_limit_s) begin
                    state_nxt_s = ST_HUNG;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HUNG: state_nxt_s = ST_HUNG;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, measurement and registered outputs. Outputs are decoded from the
    // next state so they line up with the state register without any
    // combinational path from inputs to outputs.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_r     <= ST_IDLE;
            counter_r   <= {CNT_W{1'b0}};
            total_r     <= {ACC_W{1'b0}};
            enable_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            latency_r   <= {CNT_W{1'b0}};
            run_num_r   <= {(LOG2_RUNS+1){1'b0}};
            avg_cyc_r   <= {CNT_W{1'b0}};
            avg_valid_r <= 1'b0;
            timeout_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            enable_r  <= (state_nxt_s == ST_LAUNCH);
            busy_r    <= (state_nxt_s == ST_LAUNCH) || (state_nxt_s == ST_RUN);
            timeout_r <= (state_nxt_s == ST_HUNG);
            done_r    <= run_done_s;

            // Counter reads 1 in the first RUN cycle, so latency = Tv - T0.
            if (state_r == ST_LAUNCH) begin
                counter_r <= CNT_W'(1);
            end else if ((state_r == ST_RUN) && !valid && !at_limit_s) begin
                counter_r <= counter_r + CNT_W'(1);
            end else begin
                counter_r <= counter_r;
            end

            if (run_done_s) begin
                latency_r <= counter_r;
                run_num_r <= run_num_r + (LOG2_RUNS+1)'(1);
                total_r   <= total_r + ACC_W'(counter_r);
            end else begin
                latency_r <= latency_r;
                run_num_r <= run_num_r;
                total_r   <= total_r;
            end

            // Average follows the final accumulation by one cycle; the total
            // is frozen once the batch is full, so it stays stable afterwards.
            if (batch_full_s) begin
                avg_cyc_r   <= CNT_W'(total_r >> LOG2_RUNS);
                avg_valid_r <= 1'b1;
            end else begin
                avg_cyc_r   <= avg_cyc_r;
                avg_valid_r <= avg_valid_r;
            end
        end
    end

    assign enable    = enable_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign latency   = latency_r;
    assign run_num   = run_num_r;
    assign avg_cyc   = avg_cyc_r;
    assign avg_valid = avg_valid_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: the bench plays the top model and raises valid a
// chosen number of cycles after each enable. Each expected latency is queued
// when its start is driven and compared when done pulses.
module tb_run_monitor;

    localparam int CNT_W       = 32;
    localparam int TIMEOUT_CYC = 16;
    localparam int LOG2_RUNS   = 2;
    localparam int ACC_W       = 40;

    logic                 clk = 1'b0;
    logic                 srst;
    logic                 start;
    logic                 valid;
    logic                 enable;
    logic                 busy;
    logic                 done;
    logic [CNT_W-1:0]     latency;
    logic [LOG2_RUNS:0]   run_num;
    logic [CNT_W-1:0]     avg_cyc;
    logic                 avg_valid;
    logic                 timeout;

    int vectors     = 0;
    int miscompares = 0;
    int enable_cnt  = 0;
    int done_cnt    = 0;
    int en0;
    int d0;
    int unsigned exp_q[$];

    run_monitor #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .LOG2_RUNS   (LOG2_RUNS),
        .ACC_W       (ACC_W)
    ) dut (
        .clk       (clk),
        .srst      (srst),
        .start     (start),
        .enable    (enable),
        .valid     (valid),
        .busy      (busy),
        .done      (done),
        .latency   (latency),
        .run_num   (run_num),
        .avg_cyc   (avg_cyc),
        .avg_valid (avg_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor on the falling edge; the stimulus acts 1 time unit later.
    always @(negedge clk) begin
        if (enable === 1'b1) enable_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check_val("done_unexpected", 64'd1, 64'd0);
            end else begin
                check_val("sb_latency", 64'(latency), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        srst  = 1'b1;
        start = 1'b0;
        valid = 1'b0;
        step(1);
        srst  = 1'b0;
        exp_q.delete();
    endtask

    // One normal run: valid is first sampled lat cycles after the enable cycle.
    task automatic run(input int lat);
        start = 1'b1;
        exp_q.push_back(lat);
        step(1);
        start = 1'b0;
        step(lat);
        valid = 1'b1;
        step(1);
        valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check_val("rst_enable", 64'(enable), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_latency", 64'(latency), 64'd0);
        check_val("rst_run_num", 64'(run_num), 64'd0);
        check_val("rst_avg", 64'(avg_cyc), 64'd0);
        check_val("rst_avg_valid", 64'(avg_valid), 64'd0);
        check_val("rst_timeout", 64'(timeout), 64'd0);

        // Single run, latency 5
        en0 = enable_cnt;
        start = 1'b1;
        exp_q.push_back(5);
        step(1);
        start = 1'b0;
        check_val("single_enable_hi", 64'(enable), 64'd1);
        check_val("single_busy_launch", 64'(busy), 64'd1);
        step(1);
        check_val("single_enable_lo", 64'(enable), 64'd0);
        step(4);
        valid = 1'b1;
        step(1);
        valid = 1'b0;
        check_val("single_done", 64'(done), 64'd1);
        check_val("single_latency", 64'(latency), 64'd5);
        check_val("single_run_num", 64'(run_num), 64'd1);
        check_val("single_enables", 64'(enable_cnt - en0), 64'd1);
        step(1);
        check_val("single_done_lo", 64'(done), 64'd0);
        check_val("single_busy_lo", 64'(busy), 64'd0);

        // Minimum latency, valid already high during LAUNCH
        do_reset();
        start = 1'b1;
        exp_q.push_back(1);
        step(1);
        start = 1'b0;
        valid = 1'b1;
        step(2);
        valid = 1'b0;
        check_val("min_done", 64'(done), 64'd1);
        check_val("min_latency", 64'(latency), 64'd1);

        // Batch of four runs, then a fifth start
        do_reset();
        run(3);
        run(5);
        run(7);
        run(9);
        check_val("batch_run_num", 64'(run_num), 64'd4);
        check_val("batch_avg_valid_early", 64'(avg_valid), 64'd0);
        step(1);
        check_val("batch_avg_valid", 64'(avg_valid), 64'd1);
        check_val("batch_avg_cyc", 64'(avg_cyc), 64'd6);
        en0 = enable_cnt;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        check_val("batch_fifth_enable", 64'(enable_cnt - en0), 64'd0);
        check_val("batch_fifth_busy", 64'(busy), 64'd0);
        check_val("batch_fifth_run_num", 64'(run_num), 64'd4);
        check_val("batch_avg_hold", 64'(avg_cyc), 64'd6);

        // Hang: valid never arrives
        do_reset();
        d0 = done_cnt;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(TIMEOUT_CYC);
        check_val("hang_timeout_pre", 64'(timeout), 64'd0);
        check_val("hang_busy_pre", 64'(busy), 64'd1);
        step(1);
        check_val("hang_timeout", 64'(timeout), 64'd1);
        check_val("hang_busy", 64'(busy), 64'd0);
        en0 = enable_cnt;
        start = 1'b1;
        valid = 1'b1;
        step(3);
        start = 1'b0;
        valid = 1'b0;
        step(2);
        check_val("hang_start_ignored", 64'(enable_cnt - en0), 64'd0);
        check_val("hang_no_done", 64'(done_cnt - d0), 64'd0);
        check_val("hang_sticky", 64'(timeout), 64'd1);
        do_reset();
        check_val("hang_srst_clear", 64'(timeout), 64'd0);

        // Race: valid on the threshold cycle
        run(TIMEOUT_CYC);
        check_val("race_done", 64'(done), 64'd1);
        check_val("race_latency", 64'(latency), 64'd16);
        check_val("race_timeout", 64'(timeout), 64'd0);
        step(2);
        check_val("race_timeout_later", 64'(timeout), 64'd0);

        // start held while busy, then srst mid-run
        do_reset();
        en0 = enable_cnt;
        d0 = done_cnt;
        start = 1'b1;
        step(10);
        start = 1'b0;
        check_val("busy_one_enable", 64'(enable_cnt - en0), 64'd1);
        check_val("busy_mid_run", 64'(busy), 64'd1);
        srst = 1'b1;
        step(1);
        srst = 1'b0;
        check_val("midrst_busy", 64'(busy), 64'd0);
        check_val("midrst_enable", 64'(enable), 64'd0);
        check_val("midrst_latency", 64'(latency), 64'd0);
        check_val("midrst_run_num", 64'(run_num), 64'd0);
        check_val("midrst_timeout", 64'(timeout), 64'd0);
        valid = 1'b1;
        step(3);
        valid = 1'b0;
        step(1);
        check_val("late_valid_done", 64'(done_cnt - d0), 64'd0);
        check_val("late_valid_latency", 64'(latency), 64'd0);
        check_val("late_valid_run_num", 64'(run_num), 64'd0);

        check_val("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
